// File: rtl/tow_match_scorer.sv
// Tug-of-war scorer: moves the rope position on arbitrated pushes, tracks
// round wins per player and locks once either player has won the match.
module tow_match_scorer #(
  parameter int STEPS        = 3,
  parameter int FTL          = 1,
  parameter int GAMES_TO_WIN = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               winrnd,
  input  logic               right,
  input  logic               leds_on,
  input  logic               next_game,
  output logic [2*STEPS:0]   score,
  output logic [2:0]         games_l,
  output logic [2:0]         games_r,
  output logic               round_over,
  output logic               match_over,
  output logic               foul
);

  typedef enum logic [1:0] {
    S_PLAY       = 2'd0,
    S_ROUND_WON  = 2'd1,
    S_MATCH_OVER = 2'd2
  } state_e;

  localparam logic signed [4:0] P_S    = 5'(STEPS);
  localparam logic signed [4:0] N_S    = -P_S;
  localparam logic signed [4:0] WIN_R  = 5'(STEPS + 1);
  localparam logic signed [4:0] WIN_L  = -WIN_R;
  localparam logic [2:0]        GTW    = 3'(GAMES_TO_WIN);
  localparam logic [2:0]        GTW_M1 = 3'(GAMES_TO_WIN - 1);

  state_e            state_q;
  logic signed [4:0] pos_q;
  logic signed [4:0] pos_d;
  logic [2:0]        games_l_q;
  logic [2:0]        games_r_q;
  logic              foul_q;
  logic              mr;

  // Candidate position if the current push is accepted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    mr    = ~(right ^ leds_on);
    pos_d = pos_q;
    if (mr) begin
      if (FTL != 0 && leds_on && pos_q == N_S) pos_d = pos_q + 5'sd2;
      else                                     pos_d = pos_q + 5'sd1;
    end else begin
      if (FTL != 0 && leds_on && pos_q == P_S) pos_d = pos_q - 5'sd2;
      else                                     pos_d = pos_q - 5'sd1;
    end
  end

  // NOTE: state is updated with non-blocking assignments; rst is asynchronous so it sits in the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_PLAY;
      pos_q     <= '0;
      games_l_q <= '0;
      games_r_q <= '0;
      foul_q    <= 1'b0;
    end else begin
      foul_q <= 1'b0;
      case (state_q)
        S_PLAY: begin
          if (winrnd) begin
            pos_q  <= pos_d;
            foul_q <= ~leds_on;
            if (pos_d == WIN_R) begin
              if (games_r_q < GTW) games_r_q <= games_r_q + 3'd1;
              state_q <= (games_r_q >= GTW_M1) ? S_MATCH_OVER : S_ROUND_WON;
            end else if (pos_d == WIN_L) begin
              if (games_l_q < GTW) games_l_q <= games_l_q + 3'd1;
              state_q <= (games_l_q >= GTW_M1) ? S_MATCH_OVER : S_ROUND_WON;
            end
          end
        end
        S_ROUND_WON: begin
          if (next_game) begin
            pos_q   <= '0;
            state_q <= S_PLAY;
          end
        end
        S_MATCH_OVER: ;
        default: state_q <= S_PLAY;
      endcase
    end
  end

  // LED bar decode from the registered position; an out-of-range code lights everything.
  always_comb begin
    score = '0;
    if (pos_q == WIN_L) begin
      for (int i = 0; i <= 2*STEPS; i++) score[i] = (i > STEPS);
    end else if (pos_q == WIN_R) begin
      for (int i = 0; i <= 2*STEPS; i++) score[i] = (i < STEPS);
    end else if (pos_q >= N_S && pos_q <= P_S) begin
      for (int i = 0; i <= 2*STEPS; i++) score[i] = (i == STEPS - int'(pos_q));
    end else begin
      score = '1;
    end
  end

  assign games_l    = games_l_q;
  assign games_r    = games_r_q;
  assign foul       = foul_q;
  assign round_over = (state_q != S_PLAY);
  assign match_over = (state_q == S_MATCH_OVER);

endmodule

// File: tb/tb_tow_match_scorer.sv
// Bench for tow_match_scorer: two parameterisations driven in lockstep and
// compared every cycle against an arithmetic model of the match rules.
module tb_tow_match_scorer;

  typedef struct packed {
    int steps;
    int ftl;
    int gtw;
    int pos;
    int gl;
    int gr;
    bit rover;
    bit mover;
    bit foul;
  } model_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        winrnd = 1'b0;
  logic        right = 1'b0;
  logic        leds_on = 1'b0;
  logic        next_game = 1'b0;

  logic [6:0]  score_a;
  logic [2:0]  games_l_a, games_r_a;
  logic        round_over_a, match_over_a, foul_a;
  logic [10:0] score_b;
  logic [2:0]  games_l_b, games_r_b;
  logic        round_over_b, match_over_b, foul_b;

  int n_checks = 0;
  int n_errors = 0;
  model_t ma, mb;

  always #5 clk = ~clk;

  tow_match_scorer #(.STEPS(3), .FTL(1), .GAMES_TO_WIN(2)) dut_a (
    .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .leds_on(leds_on),
    .next_game(next_game), .score(score_a), .games_l(games_l_a), .games_r(games_r_a),
    .round_over(round_over_a), .match_over(match_over_a), .foul(foul_a)
  );

  tow_match_scorer #(.STEPS(5), .FTL(0), .GAMES_TO_WIN(2)) dut_b (
    .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .leds_on(leds_on),
    .next_game(next_game), .score(score_b), .games_l(games_l_b), .games_r(games_r_b),
    .round_over(round_over_b), .match_over(match_over_b), .foul(foul_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic model_t model_reset(input int steps, input int ftl, input int gtw);
    model_t m;
    m = '0;
    m.steps = steps;
    m.ftl   = ftl;
    m.gtw   = gtw;
    return m;
  endfunction

  // One clock edge of the match rules.
  function automatic model_t model_step(input model_t m, input bit w, input bit r,
                                        input bit l, input bit ng);
    bit toward_r;
    int step;
    m.foul = 1'b0;
    if (!m.rover && !m.mover) begin
      if (w) begin
        toward_r = (r == l);
        step = 1;
        if (m.ftl != 0 && l && toward_r && m.pos == -m.steps) step = 2;
        if (m.ftl != 0 && l && !toward_r && m.pos == m.steps) step = 2;
        m.pos  = toward_r ? m.pos + step : m.pos - step;
        m.foul = !l;
        if (m.pos == m.steps + 1) begin
          m.gr++;
          if (m.gr >= m.gtw) m.mover = 1'b1; else m.rover = 1'b1;
        end else if (m.pos == -(m.steps + 1)) begin
          m.gl++;
          if (m.gl >= m.gtw) m.mover = 1'b1; else m.rover = 1'b1;
        end
      end
    end else if (m.rover && !m.mover && ng) begin
      m.pos   = 0;
      m.rover = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [31:0] exp_score(input model_t m);
    logic [31:0] s;
    s = '0;
    if (m.pos == m.steps + 1) begin
      for (int i = 0; i < m.steps; i++) s[i] = 1'b1;
    end else if (m.pos == -(m.steps + 1)) begin
      for (int i = m.steps + 1; i <= 2*m.steps; i++) s[i] = 1'b1;
    end else begin
      s[m.steps - m.pos] = 1'b1;
    end
    return s;
  endfunction

  task automatic check_all();
    check("a_score",      32'(score_a),      exp_score(ma));
    check("a_games_l",    32'(games_l_a),    32'(ma.gl));
    check("a_games_r",    32'(games_r_a),    32'(ma.gr));
    check("a_round_over", 32'(round_over_a), 32'(ma.rover || ma.mover));
    check("a_match_over", 32'(match_over_a), 32'(ma.mover));
    check("a_foul",       32'(foul_a),       32'(ma.foul));
    check("b_score",      32'(score_b),      exp_score(mb));
    check("b_games_l",    32'(games_l_b),    32'(mb.gl));
    check("b_games_r",    32'(games_r_b),    32'(mb.gr));
    check("b_round_over", 32'(round_over_b), 32'(mb.rover || mb.mover));
    check("b_match_over", 32'(match_over_b), 32'(mb.mover));
    check("b_foul",       32'(foul_b),       32'(mb.foul));
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear with no edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    ma = model_reset(3, 1, 2);
    mb = model_reset(5, 0, 2);
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply(input bit w, input bit r, input bit l, input bit ng);
    @(negedge clk);
    winrnd    = w;
    right     = r;
    leds_on   = l;
    next_game = ng;
    @(posedge clk);
    ma = model_step(ma, w, r, l, ng);
    mb = model_step(mb, w, r, l, ng);
    #1;
    check_all();
    winrnd    = 1'b0;
    next_game = 1'b0;
  endtask

  initial begin
    ma = model_reset(3, 1, 2);
    mb = model_reset(5, 0, 2);
    do_reset();
    check("a_reset_bar", 32'(score_a), 32'h08);

    // Right player walks the rope to WR.
    for (int i = 0; i < 4; i++) apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("a_wr_bar", 32'(score_a), 32'h07);

    // Round-won hold, then simultaneous next_game and winrnd.
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b1);
    check("a_next_centre", 32'(score_a), 32'h08);

    // Favour-the-loser from L3, then a jumped light from L3.
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b1, 1'b0);
    check("a_at_l3", 32'(score_a), 32'h40);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("a_ftl_jump", 32'(score_a), 32'h10);
    for (int i = 0; i < 2; i++) apply(1'b1, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    check("a_foul_move", 32'(score_a), 32'h20);
    apply(1'b0, 1'b0, 1'b0, 1'b0);

    // Second right round win locks the match; further events are ignored.
    for (int i = 0; i < 8 && !ma.mover; i++) apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("a_match_lock", 32'(match_over_a), 32'd1);
    apply(1'b1, 1'b0, 1'b1, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();

    // Wider rope without favour-the-loser: a push off R5 moves only one step.
    for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("b_at_r5", 32'(score_b), 32'h001);
    apply(1'b1, 1'b0, 1'b1, 1'b0);
    check("b_no_ftl", 32'(score_b), 32'h002);
    do_reset();
    for (int i = 0; i < 2; i++) apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("b_at_r2", 32'(score_b), 32'h008);
    do_reset();
    check("b_async_centre", 32'(score_b), 32'h020);

    // Random play with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else apply($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
